// File: rtl/prog_loader.sv
// Boot-time stream loader: parses {LEN, word pairs, CSUM} frames into
// instruction memory writes and sequences the core's reset around each image.
module prog_loader #(
  parameter int IW        = 9,
  parameter int AW        = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  input  logic          core_done,
  output logic          core_reset,
  output logic          load_ok,
  output logic          load_err
);

  // state    | meaning
  // S_LEN_LO | waiting for length low byte
  // S_LEN_HI | waiting for length high byte, range check
  // S_LO     | waiting for low byte of a word
  // S_HI     | waiting for high byte of a word, issues the write
  // S_CSUM   | waiting for checksum byte
  // S_RUN    | image accepted, core released
  // S_HALT   | core done, held in reset, next frame may start
  // S_ERR    | bad frame, held until reset
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_LO, S_HI, S_CSUM, S_RUN, S_HALT, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    csum_q, csum_d;
  logic [AW:0]   count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          im_we_q, im_we_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [IW-1:0] im_wdata_q, im_wdata_d;
  logic          core_reset_q, core_reset_d;
  logic          load_ok_q, load_ok_d;
  logic          load_err_q, load_err_d;

  logic          accept;
  logic [15:0]   len_full;
  logic          last_word;

  assign accept    = in_valid && in_ready_q;
  assign len_full  = {in_data, len_q[7:0]};
  assign last_word = (16'(count_q) == (len_q - 16'd1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    lo_d       = lo_q;
    csum_d     = csum_q;
    count_d    = count_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    load_ok_d  = load_ok_q;

    case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          csum_d     = csum_q ^ in_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          csum_d      = csum_q ^ in_data;
          count_d     = '0;
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (in_data[7:1] != 7'd0) begin
            state_d = S_ERR;
          end else begin
            im_we_d    = 1'b1;
            im_addr_d  = count_q[AW-1:0];
            im_wdata_d = IW'({in_data[0], lo_q});
            count_d    = count_q + 1'b1;
            state_d    = last_word ? S_CSUM : S_LO;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d   = S_RUN;
            load_ok_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_RUN: begin
        if (core_done) state_d = S_HALT;
      end
      S_HALT: begin
        // The first byte of the next frame arrives here, so it seeds the checksum.
        if (accept) begin
          load_ok_d = 1'b0;
          csum_d    = in_data;
          len_d     = {8'h00, in_data};
          state_d   = S_LEN_HI;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    in_ready_d   = (state_d != S_RUN) && (state_d != S_ERR);
    core_reset_d = (state_d != S_RUN);
    load_err_d   = load_err_q || (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN_LO;
      len_q        <= '0;
      lo_q         <= '0;
      csum_q       <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_reset_q <= 1'b1;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      lo_q         <= lo_d;
      csum_q       <= csum_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_reset_q <= core_reset_d;
      load_ok_q    <= load_ok_d;
      load_err_q   <= load_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign core_reset = core_reset_q;
  assign load_ok    = load_ok_q;
  assign load_err   = load_err_q;

endmodule
